// File: rtl/dino_jump_ctrl.sv
// Dino jump controller: ground/rise/fall FSM with a fixed-shape jump arc,
// a one-deep landing jump buffer, freeze hold and leg animation toggle.
//
// Ports:
//   clk       system clock, rising-edge
//   rst       async active-low reset
//   tick      step strobe, advances the jump arc one step
//   leg_tick  animation strobe, toggles leg_sel while grounded
//   jump_req  one-cycle jump request
//   freeze    level, holds all state and outputs while high
//   y_pos     registered sprite top-left row
//   airborne  high in RISE or FALL
//   landed    one-cycle pulse on the landing step
//   leg_sel   0 = left leg up, 1 = right leg up
module dino_jump_ctrl #(
  parameter logic [8:0] GROUND_Y = 9'd146,
  parameter logic [5:0] BUF_WIN  = 6'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       leg_tick,
  input  logic       jump_req,
  input  logic       freeze,
  output logic [8:0] y_pos,
  output logic       airborne,
  output logic       landed,
  output logic       leg_sel
);

  localparam logic [1:0] S_GND  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_FALL = 2'd2;

  localparam logic [5:0] LAST_RISE = 6'd31;
  localparam logic [5:0] LAST_STEP = 6'd63;

  logic [1:0] state_q, state_d;
  logic [5:0] step_q, step_d;
  logic [8:0] y_q, y_d;
  logic       pend_q, pend_d;
  logic       land_q, land_d;
  logic       leg_q, leg_d;
  logic       air_q, air_d;

  logic [8:0] dy;
  logic       in_win;
  logic       pend_now;

  // Signed step size as a 9-bit two's complement addend;
  // the arc sums to zero over 64 steps.
  always_comb begin
    dy = 9'd0;
    unique case (1'b1)
      (step_q <= 6'd9):
        dy = 9'h1FA;
      (step_q >= 6'd10 && step_q <= 6'd19):
        dy = 9'h1FC;
      (step_q >= 6'd20 && step_q <= 6'd31):
        dy = 9'h1FE;
      (step_q >= 6'd32 && step_q <= 6'd43):
        dy = 9'd2;
      (step_q >= 6'd44 && step_q <= 6'd53):
        dy = 9'd4;
      default:
        dy = 9'd6;
    endcase
  end

  // Widened compare so BUF_WIN = 0 means an empty window.
  assign in_win =
    ({1'b0, step_q} >= (7'd64 - {1'b0, BUF_WIN}));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    y_d      = y_q;
    pend_d   = pend_q;
    land_d   = 1'b0;
    leg_d    = leg_q;
    pend_now = 1'b0;
    if (!freeze) begin
      unique case (state_q)
        S_GND: begin
          if (leg_tick) begin
            leg_d = ~leg_q;
          end
          // A tick in the accept cycle is not a step.
          if (jump_req) begin
            state_d = S_RISE;
            step_d  = 6'd0;
            pend_d  = 1'b0;
          end
        end
        S_RISE: begin
          if (tick) begin
            y_d    = y_q + dy;
            step_d = step_q + 6'd1;
            if (step_q == LAST_RISE) begin
              state_d = S_FALL;
            end
          end
        end
        S_FALL: begin
          // A request on the landing cycle itself still counts.
          pend_now = pend_q | (jump_req & in_win);
          if (tick && step_q == LAST_STEP) begin
            y_d     = GROUND_Y;
            step_d  = 6'd0;
            land_d  = 1'b1;
            pend_d  = 1'b0;
            state_d = pend_now ? S_RISE : S_GND;
          end else begin
            pend_d = pend_now;
            if (tick) begin
              y_d    = y_q + dy;
              step_d = step_q + 6'd1;
            end
          end
        end
        default: begin
          state_d = S_GND;
          step_d  = 6'd0;
          y_d     = GROUND_Y;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  assign air_d = (state_d != S_GND);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_GND;
      step_q  <= 6'd0;
      y_q     <= GROUND_Y;
      pend_q  <= 1'b0;
      land_q  <= 1'b0;
      leg_q   <= 1'b0;
      air_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      land_q  <= land_d;
      leg_q   <= leg_d;
      air_q   <= air_d;
    end
  end

  assign y_pos    = y_q;
  assign airborne = air_q;
  assign landed   = land_q;
  assign leg_sel  = leg_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Scoreboard bench for dino_jump_ctrl: directed scenarios then random
// stimulus, checked against a step-count model of the jump arc.
module tb_dino_jump_ctrl;

  localparam logic [8:0] GY = 9'd146;
  localparam int BW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       leg_tick = 1'b0;
  logic       jump_req = 1'b0;
  logic       freeze = 1'b0;
  logic [8:0] y_pos;
  logic       airborne;
  logic       landed;
  logic       leg_sel;

  always #5 clk = ~clk;

  dino_jump_ctrl #(
    .GROUND_Y(GY),
    .BUF_WIN(6'd8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .leg_tick(leg_tick),
    .jump_req(jump_req),
    .freeze(freeze),
    .y_pos(y_pos),
    .airborne(airborne),
    .landed(landed),
    .leg_sel(leg_sel)
  );

  typedef struct {
    int         due;
    logic [8:0] y;
    logic       air;
    logic       land;
    logic       leg;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: grounded flag plus number of arc steps taken.
  bit m_gnd = 1'b1;
  int m_n = 0;
  bit m_pend = 1'b0;
  bit m_leg = 1'b0;
  bit m_land = 1'b0;

  function automatic int delta(input int k);
    if (k < 10) return -6;
    if (k < 20) return -4;
    if (k < 32) return -2;
    if (k < 44) return 2;
    if (k < 54) return 4;
    return 6;
  endfunction

  function automatic logic [8:0] model_y();
    int y;
    y = GY;
    if (!m_gnd)
      for (int k = 0; k < m_n; k++) y += delta(k);
    return 9'(y);
  endfunction

  task automatic model_step(input bit t, input bit lt,
                            input bit jr, input bit fz);
    bit pn;
    m_land = 1'b0;
    if (fz) return;
    if (m_gnd) begin
      if (lt) m_leg = !m_leg;
      if (jr) begin
        m_gnd = 1'b0;
        m_n = 0;
        m_pend = 1'b0;
      end
    end else begin
      pn = m_pend || (jr && m_n >= 32 && m_n >= 64 - BW);
      if (t && m_n == 63) begin
        m_land = 1'b1;
        m_pend = 1'b0;
        if (pn) m_n = 0;
        else m_gnd = 1'b1;
      end else begin
        m_pend = pn;
        if (t) m_n++;
      end
    end
  endtask

  task automatic model_reset();
    m_gnd = 1'b1;
    m_n = 0;
    m_pend = 1'b0;
    m_leg = 1'b0;
    m_land = 1'b0;
  endtask

  task automatic cyc_step(input bit t, input bit lt,
                          input bit jr, input bit fz);
    exp_t e;
    @(posedge clk);
    #1;
    tick = t;
    leg_tick = lt;
    jump_req = jr;
    freeze = fz;
    model_step(t, lt, jr, fz);
    e.due = cyc + 1;
    e.y = model_y();
    e.air = !m_gnd;
    e.land = m_land;
    e.leg = m_leg;
    sb.push_back(e);
  endtask

  task automatic settle();
    cyc_step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc_step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    tick = 1'b0;
    leg_tick = 1'b0;
    jump_req = 1'b0;
    freeze = 1'b0;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("rst_y", y_pos, GY);
    chk("rst_air", 9'(airborne), 9'd0);
    chk("rst_land", 9'(landed), 9'd0);
    chk("rst_leg", 9'(leg_sel), 9'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents outputs; compare all
  // expectations due this cycle.
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        me = sb.pop_front();
        n_chk++;
        if (me.due < cyc) begin
          n_fail++;
          $display("FAIL sb_stale: due %0d at cyc %0d", me.due, cyc);
        end else if ({y_pos, airborne, landed, leg_sel} !==
                     {me.y, me.air, me.land, me.leg}) begin
          n_fail++;
          $display("FAIL sb cyc=%0d: got y=%0d air=%0b land=%0b leg=%0b want y=%0d air=%0b land=%0b leg=%0b",
                   cyc, y_pos, airborne, landed, leg_sel,
                   me.y, me.air, me.land, me.leg);
        end
      end
    end
  end

  initial begin
    bit fz;
    #1 rst = 1'b0;
    #1;
    chk("init_y", y_pos, GY);
    chk("init_air", 9'(airborne), 9'd0);
    chk("init_land", 9'(landed), 9'd0);
    chk("init_leg", 9'(leg_sel), 9'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Legs toggle on the ground.
    repeat (3) cyc_step(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    chk("leg3", 9'(leg_sel), 9'd1);

    // Basic jump; the accept-cycle tick is not a step.
    cyc_step(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("accept_y", y_pos, GY);
    chk("accept_air", 9'(airborne), 9'd1);
    for (int i = 1; i <= 64; i++) begin
      cyc_step(1'b1, (i % 7) == 0, 1'b0, 1'b0);
      if (i == 10 || i == 20 || i == 32 || i == 64) begin
        settle();
        if (i == 10) chk("y10", y_pos, 9'd86);
        if (i == 20) chk("y20", y_pos, 9'd46);
        if (i == 32) chk("y32", y_pos, 9'd22);
        if (i == 64) begin
          chk("y64", y_pos, GY);
          chk("land64", 9'(landed), 9'd1);
          chk("air64", 9'(airborne), 9'd0);
          chk("leg_air", 9'(leg_sel), 9'd1);
        end
      end
    end
    settle();
    chk("land_pulse", 9'(landed), 9'd0);

    // Request at step 15 is dropped.
    cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 15) cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
      cyc_step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("drop_air", 9'(airborne), 9'd0);
    ticks(5);
    settle();
    chk("drop_air2", 9'(airborne), 9'd0);
    chk("drop_y", y_pos, GY);

    // Request at step 58 is buffered into a re-jump.
    cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 58) cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
      cyc_step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("buf_land", 9'(landed), 9'd1);
    chk("buf_air", 9'(airborne), 9'd1);
    ticks(1);
    settle();
    chk("buf_y", y_pos, 9'd140);
    ticks(63);
    settle();
    chk("buf_done", 9'(airborne), 9'd0);

    // Freeze mid-rise holds everything.
    cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(20);
    settle();
    chk("frz_pre", y_pos, 9'd46);
    for (int i = 0; i < 100; i++)
      cyc_step(1'b1, 1'b1, i == 50, 1'b1);
    settle();
    chk("frz_y", y_pos, 9'd46);
    chk("frz_air", 9'(airborne), 9'd1);
    ticks(44);
    settle();
    chk("frz_end_air", 9'(airborne), 9'd0);
    chk("frz_end_y", y_pos, GY);
    ticks(5);
    settle();
    chk("frz_nojump", 9'(airborne), 9'd0);

    // Reset mid-flight, then a fresh jump.
    cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(40);
    do_reset();
    cyc_step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    settle();
    chk("rst_rejump", y_pos, 9'd140);
    ticks(63);

    // Random traffic with bursty freeze.
    fz = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) fz = !fz;
      if ($urandom_range(0, 1999) == 0) begin
        do_reset();
        fz = 1'b0;
      end else begin
        cyc_step($urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15) == 0, fz);
      end
    end
    settle();
    repeat (3) @(posedge clk);
    #3;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
